// File: rtl/data_memory_pkg.sv
// Shared types and constants for the byte-addressable data memory.
// Encodes the access-size field and the init/run controller states.
package data_memory_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/data_memory_lane_align.sv
// Lane steering for sub-word accesses: load extraction/extension, store
// byte enables with lane replication, and the alignment check.
module mem_lane_align
    import data_memory_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    input  logic [31:0] word_data,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [3:0]  byte_en,
    output logic [31:0] store_data,
    output logic        misaligned
);

    logic [31:0] shifted;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Little-endian: lane 0 is the least significant byte of the word.
    always_comb begin
        shifted = word_data >> {lane, 3'b000};
        ld_byte = shifted[7:0];
        ld_half = lane[1] ? word_data[31:16] : word_data[15:0];
    end

    always_comb begin
        load_data = '0;
        case (size)
            SZ_BYTE: load_data = ld_unsigned ? {24'h0, ld_byte}
                                             : {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: load_data = ld_unsigned ? {16'h0, ld_half}
                                             : {{16{ld_half[15]}}, ld_half};
            SZ_WORD: load_data = word_data;
            default: load_data = '0;
        endcase
    end

    // Replicating wdata onto every lane lets the byte enables alone pick
    // which lanes land, so the array write needs no per-lane shifter.
    always_comb begin
        byte_en    = 4'b0000;
        store_data = '0;
        case (size)
            SZ_BYTE: begin
                byte_en    = 4'b0001 << lane;
                store_data = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                byte_en    = lane[1] ? 4'b1100 : 4'b0011;
                store_data = {2{wdata[15:0]}};
            end
            SZ_WORD: begin
                byte_en    = 4'b1111;
                store_data = wdata;
            end
            default: begin
                byte_en    = 4'b0000;
                store_data = '0;
            end
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        case (size)
            SZ_BYTE:    misaligned = 1'b0;
            SZ_HALF:    misaligned = lane[0];
            SZ_WORD:    misaligned = (lane != 2'b00);
            default:    misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Single-cycle MIPS data memory: combinational loads, edge-triggered stores,
// self-clearing after reset, with misalignment/range flags and a sticky fault.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        misaligned,
    output logic        out_of_range,
    output logic        fault
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) * 33'(BYTES_PER_WORD);
    localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH_WORDS - 1);

    logic [31:0]   mem [DEPTH_WORDS];
    state_e        state;
    logic [AW-1:0] init_cnt;

    logic [31:0]   off;
    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic [31:0]   word_data;
    logic [31:0]   load_data;
    logic [3:0]    byte_en;
    logic [31:0]   store_data;
    logic          align_bad;
    logic          range_bad;
    logic          request;
    logic          faulting;
    logic          store_en;

    always_comb begin
        off      = addr - ADDR_BASE;
        word_idx = off[AW+1:2];
        lane     = off[1:0];
    end

    // Handshake: ready is a level, not a per-transfer strobe. A request
    // (mem_read|mem_write) is honoured only in a cycle where ready=1; while
    // ready=0 requests are dropped silently and raise no flags.
    always_comb begin
        ready     = (state == ST_RUN);
        request   = ready & (mem_read | mem_write);
        range_bad = ({1'b0, off} >= MEM_BYTES);
    end

    assign word_data = mem[word_idx];

    mem_lane_align u_lane_align (
        .lane        (lane),
        .size        (size),
        .ld_unsigned (ld_unsigned),
        .word_data   (word_data),
        .wdata       (wdata),
        .load_data   (load_data),
        .byte_en     (byte_en),
        .store_data  (store_data),
        .misaligned  (align_bad)
    );

    always_comb begin
        misaligned   = request & align_bad;
        out_of_range = request & range_bad;
        faulting     = misaligned | out_of_range;
        store_en     = request & mem_write & ~faulting;
        rdata        = (request & mem_read & ~faulting) ? load_data : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            fault    <= 1'b0;
        end else begin
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + AW'(1);
                if (init_cnt == LAST_WORD) begin
                    state <= ST_RUN;
                end
            end
            if (faulting) begin
                fault <= 1'b1;
            end
        end
    end

    // The array has no reset of its own; the init sweep clears it one word
    // per cycle, and reset blocks any write in the cycle it is asserted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_INIT) begin
                mem[init_cnt] <= '0;
            end else if (store_en) begin
                for (int i = 0; i < BYTES_PER_WORD; i++) begin
                    if (byte_en[i]) begin
                        mem[word_idx][8*i +: 8] <= store_data[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed and randomized checks of data_memory against a byte-array
// reference model with sticky-fault tracking.
module tb_data_memory;

    localparam int DEPTH = 256;
    localparam int BYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        ld_unsigned;
    logic [31:0] rdata;
    logic        ready;
    logic        misaligned;
    logic        out_of_range;
    logic        fault;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] ref_mem [BYTES];
    logic       ref_fault;
    logic [31:0] got;

    always #5 clk = ~clk;

    data_memory #(.DEPTH_WORDS(DEPTH), .ADDR_BASE(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .addr         (addr),
        .wdata        (wdata),
        .size         (size),
        .ld_unsigned  (ld_unsigned),
        .rdata        (rdata),
        .ready        (ready),
        .misaligned   (misaligned),
        .out_of_range (out_of_range),
        .fault        (fault)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic ref_oor(input logic [31:0] a);
        return a >= 32'(BYTES);
    endfunction

    function automatic logic ref_mis(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] v;
        v = '0;
        case (sz)
            2'b00: begin
                b = ref_mem[a[9:0]];
                v = uns ? {24'h0, b} : {{24{b[7]}}, b};
            end
            2'b01: begin
                h = {ref_mem[a[9:0] + 10'd1], ref_mem[a[9:0]]};
                v = uns ? {16'h0, h} : {{16{h[15]}}, h};
            end
            2'b10: v = {ref_mem[a[9:0] + 10'd3], ref_mem[a[9:0] + 10'd2],
                        ref_mem[a[9:0] + 10'd1], ref_mem[a[9:0]]};
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        int n;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        for (int i = 0; i < n; i++) begin
            ref_mem[a[9:0] + 10'(i)] = d[8*i +: 8];
        end
    endtask

    task automatic ref_init();
        for (int i = 0; i < BYTES; i++) ref_mem[i] = 8'h00;
        ref_fault = 1'b0;
    endtask

    // Entered and left one time unit after a rising edge.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] sz, input logic uns,
                          input string tag, output logic [31:0] observed);
        logic oor, mis, flt;
        logic [31:0] exp_rd;
        mem_read = rd; mem_write = wr; addr = a; wdata = d; size = sz; ld_unsigned = uns;
        #1;
        oor = (rd | wr) && ref_oor(a);
        mis = (rd | wr) && ref_mis(a, sz);
        flt = oor | mis;
        exp_rd = '0;
        if (rd && !flt) exp_rd = ref_load(a, sz, uns);
        observed = rdata;
        check({tag, " rdata"}, rdata, exp_rd);
        check({tag, " misaligned"}, 32'(misaligned), 32'(mis));
        check({tag, " out_of_range"}, 32'(out_of_range), 32'(oor));
        check({tag, " ready"}, 32'(ready), 32'd1);
        @(posedge clk); #1;
        if (wr && !flt) ref_store(a, d, sz);
        if (flt) ref_fault = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0;
        check({tag, " fault"}, 32'(fault), 32'(ref_fault));
    endtask

    task automatic wait_ready(input string tag);
        int cnt;
        cnt = 0;
        while (ready !== 1'b1 && cnt < 1000) begin
            @(posedge clk); #1;
            cnt++;
        end
        check(tag, 32'(cnt), 32'd256);
    endtask

    task automatic reset_and_init(input string tag);
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        ref_init();
        wait_ready(tag);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [1:0]  sz;
        int          pick, op;

        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
        size = 2'b00; ld_unsigned = 1'b0;

        // Reset state, with a faulty-looking request applied.
        @(posedge clk); #1;
        mem_read = 1'b1; size = 2'b11; addr = 32'h401;
        #1;
        check("reset ready", 32'(ready), 32'd0);
        check("reset rdata", rdata, 32'd0);
        check("reset misaligned", 32'(misaligned), 32'd0);
        check("reset out_of_range", 32'(out_of_range), 32'd0);
        check("reset fault", 32'(fault), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ref_init();
        #1;
        check("init rdata", rdata, 32'd0);
        check("init misaligned", 32'(misaligned), 32'd0);
        check("init out_of_range", 32'(out_of_range), 32'd0);
        wait_ready("init cycles");
        mem_read = 1'b0; size = 2'b00;
        check("init no fault", 32'(fault), 32'd0);

        // Preload garbage, then raise the fault.
        access(1'b0, 1'b1, 32'h3FC, 32'hCAFE_F00D, 2'b10, 1'b0, "garbage 3fc", got);
        access(1'b0, 1'b1, 32'h040, 32'h1234_5678, 2'b10, 1'b0, "garbage 40", got);
        access(1'b1, 1'b0, 32'h3FC, 32'h0, 2'b10, 1'b0, "garbage rd", got);
        check("garbage readback", got, 32'hCAFE_F00D);
        access(1'b0, 1'b1, 32'h033, 32'hFFFF, 2'b01, 1'b0, "pre fault", got);

        // Reset in the same cycle as a store.
        rst = 1'b1; mem_write = 1'b1; addr = 32'h40; wdata = 32'hAAAA_5555; size = 2'b10;
        @(posedge clk); #1;
        mem_write = 1'b0;
        check("midrst fault cleared", 32'(fault), 32'd0);
        check("midrst ready", 32'(ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ref_init();
        wait_ready("reinit cycles");
        access(1'b1, 1'b0, 32'h040, 32'h0, 2'b10, 1'b0, "midrst rd 40", got);
        check("midrst word 40", got, 32'h0);
        access(1'b1, 1'b0, 32'h3FC, 32'h0, 2'b10, 1'b0, "cleared rd 3fc", got);
        check("cleared word 3fc", got, 32'h0);

        // Word round trip with read-during-write.
        access(1'b1, 1'b1, 32'h010, 32'hDEAD_BEEF, 2'b10, 1'b0, "rt store", got);
        check("rt old value", got, 32'h0);
        access(1'b1, 1'b0, 32'h010, 32'h0, 2'b10, 1'b0, "rt load", got);
        check("rt new value", got, 32'hDEAD_BEEF);

        // Sub-word.
        access(1'b0, 1'b1, 32'h022, 32'h5A5A_5A80, 2'b00, 1'b0, "sb 22", got);
        access(1'b1, 1'b0, 32'h022, 32'h0, 2'b00, 1'b0, "lb 22", got);
        check("lb signed", got, 32'hFFFF_FF80);
        access(1'b1, 1'b0, 32'h022, 32'h0, 2'b00, 1'b1, "lbu 22", got);
        check("lb unsigned", got, 32'h0000_0080);
        access(1'b1, 1'b0, 32'h020, 32'h0, 2'b10, 1'b0, "lw 20 a", got);
        check("lw after sb", got, 32'h0080_0000);
        access(1'b0, 1'b1, 32'h020, 32'hABCD_1234, 2'b01, 1'b0, "sh 20", got);
        access(1'b1, 1'b0, 32'h020, 32'h0, 2'b10, 1'b0, "lw 20 b", got);
        check("lw after sh", got, 32'h0080_1234);
        access(1'b1, 1'b0, 32'h022, 32'h0, 2'b01, 1'b0, "lh 22", got);
        check("lh upper half", got, 32'h0000_0080);

        // Misaligned.
        check("no fault yet", 32'(fault), 32'd0);
        access(1'b0, 1'b1, 32'h031, 32'h0000_FFFF, 2'b01, 1'b0, "sh 31", got);
        check("fault after misaligned", 32'(fault), 32'd1);
        access(1'b1, 1'b0, 32'h030, 32'h0, 2'b10, 1'b0, "lw 30", got);
        check("word 30 unchanged", got, 32'h0);
        access(1'b1, 1'b0, 32'h030, 32'h0, 2'b11, 1'b0, "illegal size", got);
        check("illegal rdata", got, 32'h0);

        // Out of range, plus the last in-range word.
        access(1'b0, 1'b1, 32'h400, 32'h1111_1111, 2'b10, 1'b0, "sw 400", got);
        access(1'b1, 1'b0, 32'h3FC, 32'h0, 2'b10, 1'b0, "lw 3fc", got);
        check("last word untouched", got, 32'h0);
        access(1'b1, 1'b0, 32'h000, 32'h0, 2'b10, 1'b0, "lw 0", got);
        check("word 0 untouched", got, 32'h0);

        // Randomized traffic from a clean state.
        reset_and_init("random init cycles");
        for (int n = 0; n < 400; n++) begin
            pick = $urandom_range(0, 9);
            sz = (pick < 3) ? 2'b00 : (pick < 6) ? 2'b01 : (pick < 9) ? 2'b10 : 2'b11;
            a = 32'($urandom_range(0, 1100));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            d = $urandom;
            op = $urandom_range(0, 3);
            access(op[0], op[1], a, d, sz, 1'($urandom_range(0, 1)), "random", got);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
